// File: rtl/cb_logic_multi.sv
// cb_logic_multi: NCH-channel charge-balance controller with auto-zero/amplify phasing, pulse count and fail detection
module cb_logic_multi #(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int AZ_CYC     = 2,
    parameter int AMP_CYC    = 1,
    parameter int MAX_PULSES = 8,
    parameter int CNTW       = 6
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [CHW-1:0]  CH,
    input  logic            CB_ON,
    input  logic            CAN_STI,
    input  logic            ANO_STI,
    input  logic            AMP_OUT,
    output logic            AMP_ON,
    output logic            AZ_CLK,
    output logic            AZ_CLK_N,
    output logic            CB_OK,
    output logic            CB_FAIL,
    output logic [NCH-1:0]  CB_CHNL,
    output logic [CNTW-1:0] PULSE_CNT,
    output logic [NCH-1:0]  SW_ANO_N,
    output logic [NCH-1:0]  SW_CAN
);
    localparam int PCM = AZ_CYC > AMP_CYC ? AZ_CYC : AMP_CYC;
    localparam int PCW = PCM > 1 ? $clog2(PCM) : 1;
    localparam logic [PCW-1:0] AZ_LAST = PCW'(AZ_CYC - 1);
    localparam logic [PCW-1:0] AMP_LAST = PCW'(AMP_CYC - 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_PULSES);

    typedef enum logic [2:0] {IDLE, AZ, AMP, DONE, FAIL} state_t;

    state_t st, st_n;
    logic [PCW-1:0] pc, pc_n;
    logic [CHW-1:0] chq, chq_n;
    logic [CNTW-1:0] cnt_n;
    logic [NCH-1:0] ch_oh, q_oh, can_n, ano_n;
    logic fst, fst_n, sv, sv_n, ok_n, fail_n, run_n, inj;

    always_comb begin
        st_n = st;
        pc_n = pc;
        chq_n = chq;
        fst_n = fst;
        sv_n = sv;
        ok_n = CB_OK;
        fail_n = CB_FAIL;
        cnt_n = PULSE_CNT;
        if (!CB_ON) begin
            st_n = IDLE;
            pc_n = '0;
            fst_n = 1'b0;
            sv_n = 1'b0;
            ok_n = 1'b0;
            fail_n = 1'b0;
            cnt_n = '0;
        end else begin
            case (st)
                IDLE: begin
                    chq_n = CH;
                    fst_n = 1'b0;
                    pc_n = '0;
                    st_n = AZ;
                end
                AZ: if (pc == AZ_LAST) begin
                    pc_n = '0;
                    st_n = AMP;
                    if (fst && PULSE_CNT != '1) cnt_n = PULSE_CNT + 1'b1;
                end else pc_n = pc + 1'b1;
                AMP: if (pc == AMP_LAST) begin
                    pc_n = '0;
                    if (!fst) begin
                        sv_n = AMP_OUT;
                        fst_n = 1'b1;
                        st_n = AZ;
                    end else if (AMP_OUT != sv) begin
                        ok_n = 1'b1;
                        st_n = DONE;
                    end else if (PULSE_CNT == CNT_MAX) begin
                        fail_n = 1'b1;
                        st_n = FAIL;
                    end else st_n = AZ;
                end else pc_n = pc + 1'b1;
                default: ;
            endcase
        end
        ch_oh = '0;
        q_oh = '0;
        // out-of-range indices decode to all-zero, so no channel is ever driven for them
        for (int i = 0; i < NCH; i++) begin
            ch_oh[i] = CH == CHW'(i);
            q_oh[i] = chq_n == CHW'(i);
        end
        run_n = st_n == AZ || st_n == AMP;
        inj = st_n == AZ && fst_n && !CAN_STI && !ANO_STI;
        can_n = CAN_STI ? ch_oh : (inj && sv_n) ? q_oh : '0;
        ano_n = CAN_STI ? '0 : ANO_STI ? ch_oh : (inj && !sv_n) ? q_oh : '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st <= IDLE;
            pc <= '0;
            chq <= '0;
            fst <= 1'b0;
            sv <= 1'b0;
            CB_OK <= 1'b0;
            CB_FAIL <= 1'b0;
            PULSE_CNT <= '0;
            AMP_ON <= 1'b0;
            AZ_CLK <= 1'b1;
            AZ_CLK_N <= 1'b0;
            CB_CHNL <= '0;
            SW_CAN <= '0;
            SW_ANO_N <= '1;
        end else begin
            st <= st_n;
            pc <= pc_n;
            chq <= chq_n;
            fst <= fst_n;
            sv <= sv_n;
            CB_OK <= ok_n;
            CB_FAIL <= fail_n;
            PULSE_CNT <= cnt_n;
            AMP_ON <= run_n;
            AZ_CLK <= st_n != AMP;
            AZ_CLK_N <= st_n == AMP;
            CB_CHNL <= run_n ? q_oh : '0;
            SW_CAN <= can_n;
            SW_ANO_N <= ~ano_n;
        end
    end
endmodule
